// File: rtl/jar_sram_pkg.sv
// Shared defaults, arbiter state encoding and lock counter width for the
// two-port SRAM arbiter.
package jar_sram_pkg;

  localparam int AW_DEF       = 4;
  localparam int DW_DEF       = 8;
  localparam int DEPTH_DEF    = 16;
  localparam int MAX_LOCK_DEF = 4;
  localparam int LOCK_CW_DEF  = $clog2(MAX_LOCK_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/jar_sram_mem.sv
// Single-port register-file array: synchronous write, registered read.
// The array is deliberately not reset so its contents survive rst_n.
module jar_sram_mem #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write on the accepting edge; capture read data for the next cycle.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jar_sram_arbiter.sv
// Two-requester round-robin arbiter with bounded burst locking in front of
// a shared 16x8 register file. Reads answer one cycle after acceptance on
// the port that issued them.
//
// state | meaning
// IDLE  | round-robin between requesters, lp breaks ties
// LOCK0 | burst owned by requester 0, requester 1 held off
// LOCK1 | burst owned by requester 1, requester 0 held off
module jar_sram_arbiter
  import jar_sram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic          req0_lock,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic          req1_lock,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata
);

  localparam int LCW = $clog2(MAX_LOCK + 1);

  arb_state_t     state_q, state_d;
  logic           lp_q, lp_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_sel_q, rsp_sel_d;

  logic           grant0, grant1, acc, sel;
  logic           m_we, m_lock;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata, m_rdata;
  logic [LCW-1:0] cnt_inc;

  // Grant selection, port mux and next-state for FSM, lp and lock counter.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_d    = state_q;
    lp_d       = lp_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = lock_cnt_q + LCW'(1);

    case (state_q)
      IDLE: begin
        if (req0_valid && (!req1_valid || lp_q)) grant0 = 1'b1;
        else if (req1_valid)                      grant1 = 1'b1;
      end
      LOCK0:   grant0 = req0_valid;
      LOCK1:   grant1 = req1_valid;
      default: ;
    endcase

    acc     = grant0 | grant1;
    sel     = grant1;
    m_we    = sel ? req1_we    : req0_we;
    m_lock  = sel ? req1_lock  : req0_lock;
    m_addr  = sel ? req1_addr  : req0_addr;
    m_wdata = sel ? req1_wdata : req0_wdata;

    if (acc) lp_d = sel;

    case (state_q)
      IDLE: begin
        if (acc && m_lock) begin
          state_d    = sel ? LOCK1 : LOCK0;
          lock_cnt_d = LCW'(1);
        end
      end
      LOCK0, LOCK1: begin
        // Owner idle, lock dropped, or burst length exhausted all end the burst.
        if (!acc || !m_lock || cnt_inc == LCW'(MAX_LOCK)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase

    rsp_valid_d = acc & ~m_we;
    rsp_sel_d   = sel;
  end

  assign req0_ready = req0_valid & grant0;
  assign req1_ready = req1_valid & grant1;

  // Arbiter state, round-robin pointer and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lp_q       <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lp_q       <= lp_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Remember which requester owns the read data arriving next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sel_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sel_q   <= rsp_sel_d;
    end
  end

  jar_sram_mem #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (acc & m_we),
    .re_i    (acc & ~m_we),
    .addr_i  (m_addr),
    .wdata_i (m_wdata),
    .rdata_o (m_rdata)
  );

  assign rsp0_valid = rsp_valid_q & ~rsp_sel_q;
  assign rsp1_valid = rsp_valid_q &  rsp_sel_q;
  assign rsp0_rdata = rsp0_valid ? m_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? m_rdata : '0;

endmodule

// File: tb/tb_jar_sram_arbiter.sv
// Randomized and directed bench for jar_sram_arbiter against a
// transaction-level model of arbitration, locking and memory contents.
module tb_jar_sram_arbiter;
  import jar_sram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, we0, lk0, v1, we1, lk1;
  logic [3:0] a0, a1;
  logic [7:0] d0, d1;
  logic       r0, r1, rv0, rv1;
  logic [7:0] rd0, rd1;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl_mem [16];
  int         owner;
  int         lp;
  int         cnt;
  bit         erv [2];
  logic [7:0] erd;

  always #5 clk = ~clk;

  jar_sram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (v0),
    .req0_ready (r0),
    .req0_we    (we0),
    .req0_lock  (lk0),
    .req0_addr  (a0),
    .req0_wdata (d0),
    .rsp0_valid (rv0),
    .rsp0_rdata (rd0),
    .req1_valid (v1),
    .req1_ready (r1),
    .req1_we    (we1),
    .req1_lock  (lk1),
    .req1_addr  (a1),
    .req1_wdata (d1),
    .rsp1_valid (rv1),
    .rsp1_rdata (rd1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit pv0, input bit pwe0, input bit plk0, input logic [3:0] pa0,
                       input logic [7:0] pd0, input bit pv1, input bit pwe1, input bit plk1,
                       input logic [3:0] pa1, input logic [7:0] pd1);
    v0 = pv0; we0 = pwe0; lk0 = plk0; a0 = pa0; d0 = pd0;
    v1 = pv1; we1 = pwe1; lk1 = plk1; a1 = pa1; d1 = pd1;
  endtask

  task automatic model_reset();
    owner  = -1;
    lp     = 1;
    cnt    = 0;
    erv[0] = 1'b0;
    erv[1] = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; checks mid-cycle, then
  // advances the model over the coming edge.
  task automatic tick();
    int         g;
    bit         vv [2];
    bit         ww [2];
    bit         ll [2];
    logic [3:0] aa [2];
    logic [7:0] dd [2];
    #3;
    vv[0] = v0;  vv[1] = v1;
    ww[0] = we0; ww[1] = we1;
    ll[0] = lk0; ll[1] = lk1;
    aa[0] = a0;  aa[1] = a1;
    dd[0] = d0;  dd[1] = d1;

    g = -1;
    if (owner >= 0) begin
      if (vv[owner]) g = owner;
    end else if (vv[0] && vv[1]) g = 1 - lp;
    else if (vv[0]) g = 0;
    else if (vv[1]) g = 1;

    check_eq("ready0", 32'(r0), 32'(g == 0));
    check_eq("ready1", 32'(r1), 32'(g == 1));
    check_eq("rsp0_valid", 32'(rv0), 32'(erv[0]));
    check_eq("rsp0_rdata", 32'(rd0), erv[0] ? 32'(erd) : 32'h0);
    check_eq("rsp1_valid", 32'(rv1), 32'(erv[1]));
    check_eq("rsp1_rdata", 32'(rd1), erv[1] ? 32'(erd) : 32'h0);

    erv[0] = 1'b0;
    erv[1] = 1'b0;
    if (g >= 0) begin
      if (ww[g]) mdl_mem[aa[g]] = dd[g];
      else begin
        erv[g] = 1'b1;
        erd    = mdl_mem[aa[g]];
      end
      lp = g;
    end
    if (owner >= 0) begin
      if (g < 0) owner = -1;
      else begin
        cnt++;
        if (!ll[g] || cnt >= MAX_LOCK_DEF) owner = -1;
      end
    end else if (g >= 0 && ll[g]) begin
      owner = g;
      cnt   = 1;
    end

    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset between edges, holds it across one
  // edge, releases at the following posedge+1.
  task automatic reset_mid();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_rsp0_valid", 32'(rv0), 32'h0);
    check_eq("rst_rsp1_valid", 32'(rv1), 32'h0);
    check_eq("rst_rsp0_rdata", 32'(rd0), 32'h0);
    check_eq("rst_rsp1_rdata", 32'(rd1), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset: nothing granted, no responses.
    tick();

    // Preload every word so all later reads have known data.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 4'(i), 8'($urandom), 0, 0, 0, 0, 0);
      tick();
    end

    // Write 0xA5 to addr 3 from req0, then read it back from req1.
    drive(1, 1, 0, 4'd3, 8'hA5, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 4'd3, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("a5_readback", 32'(mdl_mem[3]), 32'hA5);

    // Both requesters read continuously: alternating grants.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 4'($urandom), 0, 1, 0, 0, 4'($urandom), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Bring lp back to 1 so req0 wins the burst's first contention.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 4'd1, 0);
    tick();

    // Locked burst of 6 from req0 with req1 waiting: 4 beats, req1, req0.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 4'(i), 0, 1, 0, 0, 4'd9, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Early release: req0 locks, goes idle one cycle, req1 then granted.
    drive(1, 0, 1, 4'd2, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 4'd2, 0, 1, 0, 0, 4'd7, 0);
    tick();
    drive(1, 0, 0, 4'd2, 0, 1, 0, 0, 4'd7, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Read-after-write at addr 15, reset with a read in flight, read again.
    drive(1, 1, 0, 4'd15, 8'h3C, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 4'd15, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 4'd15, 0);
    tick();
    reset_mid();
    tick();
    drive(1, 0, 0, 4'd15, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("3c_retained", 32'(mdl_mem[15]), 32'h3C);

    // Random traffic with frequent locks and occasional resets.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
            4'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
            4'($urandom), 8'($urandom));
      if ($urandom_range(0, 79) == 0) reset_mid();
      else tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jar_sram_arbiter.md
Name: jar_sram_arbiter

Overview:
- Shares one 16x8 register-file memory between two requesters.
- Uses valid/ready request handshakes, round-robin arbitration, and optional bounded burst locking.
- A read returns data through a registered response one cycle after the request is accepted.
- Sits between two client blocks, such as a pin-protocol front end and an internal sequencer, and the storage array.

Parameters:
- AW, 4, address width.
- DW, 8, data width.
- DEPTH, 16, number of words (must equal 2**AW).
- MAX_LOCK, 4, maximum beats in one locked burst (range 2..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a beat.
- req0_ready  out  1  beat accepted this cycle when valid&ready.
- req0_we  in  1  1=write, 0=read.
- req0_lock  in  1  request to keep the grant for the next beat.
- req0_addr  in  AW  word address.
- req0_wdata  in  DW  write data.
- rsp0_valid  out  1  read data valid, one-cycle pulse.
- rsp0_rdata  out  DW  read data; 0 when rsp0_valid=0.
- req1_*, rsp1_*  same set of ports and meanings for requester 1.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, last-served pointer lp=1 (requester 0 wins the first contention), lock_cnt=0.
  - rsp*_valid=0, rsp*_rdata=0.
  - The memory array is not reset; its contents survive rst_n.
- Ready handshake:
  - reqN_ready is combinational: reqN_ready = reqN_valid & grant_N.
  - At most one ready is high per cycle.
  - Ready never goes high without valid.
- Arbitration in IDLE:
  - Exactly one valid: that requester is granted.
  - Both valid: the requester != lp is granted.
  - On every accepted beat, lp takes the index of the granted requester.
- Write beat: mem[addr] <= wdata at the accepting edge. No response is generated.
- Read beat:
  - rspN_valid=1 and rspN_rdata=mem[addr] in the cycle after acceptance, for exactly one cycle.
  - Back-to-back reads give back-to-back responses in order.
- Read-after-write:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Only one port accesses the array per cycle, so no same-cycle read/write conflict exists.
- Lock FSM, states IDLE, LOCK0, LOCK1:
  - In IDLE, an accepted beat from N with lock=1 moves to LOCKN and sets lock_cnt=1.
  - In LOCKN only requester N can be granted; the other requester's ready is 0 even if N is idle.
  - An accepted beat in LOCKN increments lock_cnt.
  - Exit from LOCKN to IDLE happens on any of:
    - an accepted beat with lock=0;
    - lock_cnt reaching MAX_LOCK (that beat is the last one in the burst);
    - a cycle with reqN_valid=0 (no grant that cycle).
  - On a forced exit at MAX_LOCK, lp=N, so the other requester wins the next contention.
  - Worst-case wait for a valid requester is MAX_LOCK+1 cycles.
- Reset mid-operation:
  - A pending read response is dropped; rsp*_valid stays 0 after release.
  - The lock is released.
- Address arithmetic:
  - Addresses are AW bits with no wrap logic.
  - Out-of-range addresses are impossible when DEPTH=2**AW.
- The request inputs (valid, we, lock, addr, wdata) carry no stability requirement before acceptance.

Decomposition:
- Package jar_sram_pkg holds:
  - AW, DW, DEPTH and MAX_LOCK defaults;
  - the arb_state_t enum {IDLE, LOCK0, LOCK1};
  - the lock_cnt width localparam ($clog2(MAX_LOCK+1)).
- Sub-module jar_sram_mem contains:
  - a single-port DEPTH x DW array with a synchronous write;
  - a registered read, with rdata valid one cycle after the read enable;
  - no reset on the array.
- The arbiter top holds the FSM, lp, lock_cnt, the port mux, and the response routing register (which requester issued the read).

Test Plan:
- Reset then single writes: req0 writes 0xA5 to addr 3; req1 reads addr 3 next cycle → rsp1_valid pulses 1 cycle later with rsp1_rdata=0xA5; rsp0_valid stays 0.
- Contention round-robin: both requesters hold valid reads for 4 cycles → grants 0,1,0,1; responses arrive on the matching rsp port, one cycle after each grant.
- Lock burst, MAX_LOCK=4: req0 holds lock=1 with valid for 6 beats while req1 is valid → req0 granted cycles 1-4, req1 granted cycle 5, req0 granted cycle 6.
- Early lock release: req0 locks, then drops valid for 1 cycle while req1 is valid → no grant that cycle, FSM returns to IDLE, req1 is granted the next cycle.
- Read-after-write plus async reset: write 0x3C to addr 15, then read addr 15 → 0x3C. Assert rst_n low in the cycle after a read acceptance → no rsp_valid. After release, read addr 15 → 0x3C (memory retained).
